// File: rtl/ps2_pkg.sv
// PS/2 scan-code receiver: shared state type, prefix codes, defaults.
// Build option PS2_PARITY_CHECK_EN enables the odd-parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int PS2_TIMEOUT_DEFAULT = 200000;

  function automatic logic ps2_odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Byte-level bundle between the frame receiver and the prefix layer.
// tmo flags the timeout subset of frame_err.
interface ps2_scancode_rx_if;

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;
  logic       tmo;

  modport master (
    output rx_byte,
    output byte_valid,
    output frame_err,
    output tmo
  );

  modport slave (
    input rx_byte,
    input byte_valid,
    input frame_err,
    input tmo
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: sync, edge detect, frame FSM, parity, timeout.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ps2_clk_in,
  input  logic              ps2_data_in,
  ps2_scancode_rx_if.master frm
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state, state_n;
  logic [2:0]    bitcnt, bit_n;
  logic [7:0]    sr, sr_n;
  logic          par, par_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    clk_s, dat_s;
  logic          clk_d;
  logic          fall, d, par_ok, expire;
  logic          byte_valid, frame_err, tmo;

  assign fall   = clk_d & ~clk_s[1];
  assign d      = dat_s[1];
  assign expire = (state != IDLE) && (cnt == LIM);

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ps2_odd_ok(sr, par);
`else
  // parity bit is captured but deliberately not checked
  assign par_ok = par | 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_s  <= 2'b11;
      dat_s  <= 2'b11;
      clk_d  <= 1'b1;
      state  <= IDLE;
      bitcnt <= '0;
      sr     <= '0;
      par    <= 1'b0;
      cnt    <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk_in};
      dat_s  <= {dat_s[0], ps2_data_in};
      clk_d  <= clk_s[1];
      state  <= state_n;
      bitcnt <= bit_n;
      sr     <= sr_n;
      par    <= par_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_n      = bitcnt;
    sr_n       = sr;
    par_n      = par;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    tmo        = 1'b0;
    if (fall || state == IDLE) begin
      cnt_n = '0;
    end else if (cnt == LIM) begin
      cnt_n = cnt;
    end else begin
      cnt_n = cnt + CW'(1);
    end
    if (expire) begin
      state_n   = IDLE;
      frame_err = 1'b1;
      tmo       = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!d) begin
            state_n = DATA;
            bit_n   = '0;
          end
        end
        DATA: begin
          sr_n  = {d, sr[7:1]};
          bit_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = d;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (d && par_ok) byte_valid = 1'b1;
          else             frame_err  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign frm.rx_byte    = sr;
  assign frm.byte_valid = byte_valid;
  assign frm.frame_err  = frame_err;
  assign frm.tmo        = tmo;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 scan-code receiver top: E0/F0 prefix layer over ps2_frame_rx.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] keypress_out,
  output logic       keypress_valid_out,
  output logic       extended_out,
  output logic       error_out
);

  ps2_scancode_rx_if frm ();

  logic ext_flag;
  logic brk_flag;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .frm         (frm)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ext_flag           <= 1'b0;
      brk_flag           <= 1'b0;
      keypress_out       <= 8'h00;
      keypress_valid_out <= 1'b0;
      extended_out       <= 1'b0;
      error_out          <= 1'b0;
    end else begin
      keypress_valid_out <= 1'b0;
      error_out          <= frm.frame_err;
      if (frm.byte_valid) begin
        unique case (1'b1)
          frm.rx_byte == PS2_PREFIX_EXT: ext_flag <= 1'b1;
          frm.rx_byte == PS2_PREFIX_BRK: brk_flag <= 1'b1;
          default: begin
            // a break code releases a key: swallow it
            if (!brk_flag) begin
              keypress_out       <= frm.rx_byte;
              extended_out       <= ext_flag;
              keypress_valid_out <= 1'b1;
            end
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
        endcase
      end
      if (frm.tmo) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

endmodule
